reorder_buffer: RTL and testbench
=================================

# reorder_buffer

Banked reorder buffer sitting directly downstream of the rename/dispatch stage: accepts up to DISPATCH_WIDTH renamed instructions per cycle as one ROB row, and returns each instruction's ROB tag (row address plus bank/lane index). It tracks completion writebacks from the execution units and retires rows strictly in program order, presenting architectural/physical destination pairs to the commit consumers (RRAT, free list).

## Interface
Parameters (all from the `parameters` package):
- DISPATCH_WIDTH, 2: lanes per row; one bank per lane.
- DISPATCH_ADDR_WIDTH, $clog2(DISPATCH_WIDTH): bank index width.
- ROB_SIZE, 16: number of rows; power of two.
- ROB_ADDR_WIDTH, $clog2(ROB_SIZE): row address width.
- PHYS_REGS_ADDR_WIDTH, 6: physical register tag width.
- COMPLETE_WIDTH, 2: completion writeback ports.

Ports (clock and reset first):
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- dispatch_en[DISPATCH_WIDTH]  in  1 each  lane carries a valid instruction.
- dispatch_phys_rd[DISPATCH_WIDTH]  in  PHYS_REGS_ADDR_WIDTH each  renamed destination.
- dispatch_arch_rd[DISPATCH_WIDTH]  in  5 each  architectural destination.
- dispatch_bank_addr[DISPATCH_WIDTH]  out  DISPATCH_ADDR_WIDTH each  constant lane index i.
- dispatch_rob_addr[DISPATCH_WIDTH]  out  ROB_ADDR_WIDTH each  current tail row (same for all lanes).
- dispatch_full  out  1  no free row; dispatch ignored.
- complete_en[COMPLETE_WIDTH]  in  1 each  writeback valid.
- complete_rob_addr[COMPLETE_WIDTH]  in  ROB_ADDR_WIDTH each  row of completing instruction.
- complete_bank_addr[COMPLETE_WIDTH]  in  DISPATCH_ADDR_WIDTH each  lane of completing instruction.
- commit_en[DISPATCH_WIDTH]  out  1 each  lane retiring this cycle.
- commit_phys_rd[DISPATCH_WIDTH]  out  PHYS_REGS_ADDR_WIDTH each.
- commit_arch_rd[DISPATCH_WIDTH]  out  5 each.
- commit_rob_addr  out  ROB_ADDR_WIDTH  head row being retired.
- flush  in  1  synchronous discard of all entries.

## Operation
- Storage: ROB_SIZE rows × DISPATCH_WIDTH banks; per entry valid, done, arch_rd, phys_rd.
- Pointers head/tail are ROB_ADDR_WIDTH+1 bits (wrap bit); count = tail − head modulo 2^(ROB_ADDR_WIDTH+1).
- dispatch_full = (count == ROB_SIZE), combinational from registered pointers only.
- Dispatch fire = (any dispatch_en) && !dispatch_full && !flush: row[tail] written, lane i valid = dispatch_en[i], done = 0; tail += 1. All-zero en allocates nothing.
- dispatch_rob_addr = tail[ROB_ADDR_WIDTH-1:0]; tag is valid in the same cycle as fire.
- Completion: each complete_en sets done of addressed entry; writes to entries with valid=0 ignored. Multiple ports hitting the same entry: harmless OR.
- Commit ready = count != 0 && every valid lane of row[head] has done=1. Then commit_en[i] = valid[i], phys/arch_rd driven from row[head]; on the edge head += 1 and row valid bits cleared. Not ready: all commit_en = 0 (data outputs don't-care).
- One row committed per cycle max; no partial-row commit.
- flush: head = tail = 0, all valid/done cleared; overrides dispatch, completion, commit same cycle; commit_en forced 0 during flush cycle.

## Timing
- Reset (async, rst_n low): head = tail = 0, all valid/done = 0; dispatch_full = 0, dispatch_rob_addr = 0, commit_en = 0, commit_rob_addr = 0; bank_addr constant.
- Dispatch-to-commit minimum: dispatch cycle N, completion cycle N+1, commit_en asserted cycle N+2.
- Completion is visible to commit the cycle after complete_en (no same-cycle bypass).
- Full with simultaneous commit: dispatch still blocked that cycle; full drops next cycle.
- Empty with simultaneous dispatch: no commit that cycle (new row's done = 0).
- Dispatch and commit on same row index impossible except via wrap, prevented by full.
- Pointer wrap: row ROB_SIZE−1 followed by row 0; wrap bit distinguishes full from empty.
- rst_n deassertion mid-operation not required to preserve any state.

## Test plan
- Reset then dispatch en={1,1}, phys_rd={10,11}, arch_rd={1,2} -> rob_addr=0, bank_addr={0,1}; complete both cycle 1 -> cycle 2 commit_en={1,1}, phys_rd={10,11}, commit_rob_addr=0.
- Dispatch en={1,0} row 0, complete lane 0 -> commit_en={1,0}; completion to lane 1 of row 0 beforehand has no effect.
- Fill 16 rows without completion -> dispatch_full=1 after 16th fire; 17th dispatch ignored, tail unchanged; complete row 0 -> commit, full=0 next cycle, next dispatch gets rob_addr=0 (wrap).
- Complete row 1 before row 0 -> no commit until row 0 done; then rows 0 and 1 commit on consecutive cycles.
- flush with 5 rows occupied and dispatch active same cycle -> next cycle empty, rob_addr=0, full=0, commit_en=0.
- Assert rst_n low mid-stream -> all outputs return to reset values immediately (asynchronously).

Source files
------------

// File: rtl/reorder_buffer.sv
// reorder_buffer: banked in-order retirement buffer, one DISPATCH_WIDTH-wide row per dispatch group.
package parameters;
    localparam int DISPATCH_WIDTH       = 2;
    localparam int DISPATCH_ADDR_WIDTH  = $clog2(DISPATCH_WIDTH);
    localparam int ROB_SIZE             = 16;
    localparam int ROB_ADDR_WIDTH       = $clog2(ROB_SIZE);
    localparam int PHYS_REGS_ADDR_WIDTH = 6;
    localparam int COMPLETE_WIDTH       = 2;
endpackage

module reorder_buffer
    import parameters::*;
(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            dispatch_en        [DISPATCH_WIDTH],
    input  logic [PHYS_REGS_ADDR_WIDTH-1:0] dispatch_phys_rd   [DISPATCH_WIDTH],
    input  logic [4:0]                      dispatch_arch_rd   [DISPATCH_WIDTH],
    output logic [DISPATCH_ADDR_WIDTH-1:0]  dispatch_bank_addr [DISPATCH_WIDTH],
    output logic [ROB_ADDR_WIDTH-1:0]       dispatch_rob_addr  [DISPATCH_WIDTH],
    output logic                            dispatch_full,
    input  logic                            complete_en        [COMPLETE_WIDTH],
    input  logic [ROB_ADDR_WIDTH-1:0]       complete_rob_addr  [COMPLETE_WIDTH],
    input  logic [DISPATCH_ADDR_WIDTH-1:0]  complete_bank_addr [COMPLETE_WIDTH],
    output logic                            commit_en          [DISPATCH_WIDTH],
    output logic [PHYS_REGS_ADDR_WIDTH-1:0] commit_phys_rd     [DISPATCH_WIDTH],
    output logic [4:0]                      commit_arch_rd     [DISPATCH_WIDTH],
    output logic [ROB_ADDR_WIDTH-1:0]       commit_rob_addr,
    input  logic                            flush
);
    typedef logic [ROB_ADDR_WIDTH:0] ptr_t;
    ptr_t head_q, head_d, tail_q, tail_d, count;
    logic [DISPATCH_WIDTH-1:0] valid_q [ROB_SIZE];
    logic [DISPATCH_WIDTH-1:0] valid_d [ROB_SIZE];
    logic [DISPATCH_WIDTH-1:0] done_q  [ROB_SIZE];
    logic [DISPATCH_WIDTH-1:0] done_d  [ROB_SIZE];
    logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_q [ROB_SIZE][DISPATCH_WIDTH];
    logic [4:0] arch_q [ROB_SIZE][DISPATCH_WIDTH];
    logic [DISPATCH_WIDTH-1:0] en_vec;
    logic [ROB_ADDR_WIDTH-1:0] head_row, tail_row;
    logic fire, ready, commit;

    assign count         = tail_q - head_q;
    assign dispatch_full = count == ptr_t'(ROB_SIZE);
    assign head_row      = head_q[ROB_ADDR_WIDTH-1:0];
    assign tail_row      = tail_q[ROB_ADDR_WIDTH-1:0];
    assign fire          = |en_vec && !dispatch_full && !flush;
    // A row retires only once every occupied lane has written back.
    assign ready         = count != '0 && (valid_q[head_row] & ~done_q[head_row]) == '0;
    assign commit        = ready && !flush;
    assign commit_rob_addr = head_row;
    assign head_d        = flush ? '0 : head_q + ptr_t'(commit);
    assign tail_d        = flush ? '0 : tail_q + ptr_t'(fire);

    always_comb begin
        en_vec = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            en_vec[i]             = dispatch_en[i];
            dispatch_bank_addr[i] = DISPATCH_ADDR_WIDTH'(i);
            dispatch_rob_addr[i]  = tail_row;
            commit_en[i]          = commit && valid_q[head_row][i];
            commit_phys_rd[i]     = phys_q[head_row][i];
            commit_arch_rd[i]     = arch_q[head_row][i];
        end
    end

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        for (int c = 0; c < COMPLETE_WIDTH; c++)
            if (complete_en[c] && valid_q[complete_rob_addr[c]][complete_bank_addr[c]])
                done_d[complete_rob_addr[c]][complete_bank_addr[c]] = 1'b1;
        if (commit) begin
            valid_d[head_row] = '0;
            done_d[head_row]  = '0;
        end
        if (fire) begin
            valid_d[tail_row] = en_vec;
            done_d[tail_row]  = '0;
        end
        if (flush) begin
            valid_d = '{default: '0};
            done_d  = '{default: '0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '{default: '0};
            done_q  <= '{default: '0};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fire)
            for (int i = 0; i < DISPATCH_WIDTH; i++) begin
                phys_q[tail_row][i] <= dispatch_phys_rd[i];
                arch_q[tail_row][i] <= dispatch_arch_rd[i];
            end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed vector table plus hand sequences for full/wrap, flush and async reset.
module tb_reorder_buffer;
    import parameters::*;

    logic clk = 0;
    logic rst_n = 0;
    logic dispatch_en [2];
    logic [5:0] dispatch_phys_rd [2];
    logic [4:0] dispatch_arch_rd [2];
    logic [0:0] dispatch_bank_addr [2];
    logic [3:0] dispatch_rob_addr [2];
    logic dispatch_full;
    logic complete_en [2];
    logic [3:0] complete_rob_addr [2];
    logic [0:0] complete_bank_addr [2];
    logic commit_en [2];
    logic [5:0] commit_phys_rd [2];
    logic [4:0] commit_arch_rd [2];
    logic [3:0] commit_rob_addr;
    logic flush;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk(clk), .rst_n(rst_n),
        .dispatch_en(dispatch_en), .dispatch_phys_rd(dispatch_phys_rd),
        .dispatch_arch_rd(dispatch_arch_rd), .dispatch_bank_addr(dispatch_bank_addr),
        .dispatch_rob_addr(dispatch_rob_addr), .dispatch_full(dispatch_full),
        .complete_en(complete_en), .complete_rob_addr(complete_rob_addr),
        .complete_bank_addr(complete_bank_addr), .commit_en(commit_en),
        .commit_phys_rd(commit_phys_rd), .commit_arch_rd(commit_arch_rd),
        .commit_rob_addr(commit_rob_addr), .flush(flush)
    );

    typedef struct {
        logic [1:0] den; logic [5:0] p0, p1; logic [4:0] a0, a1;
        logic [1:0] cen; logic [3:0] cr0; logic cb0; logic [3:0] cr1; logic cb1; logic fl;
        logic full; logic [3:0] rob; logic [1:0] cmt;
        logic [5:0] cp0, cp1; logic [4:0] ca0, ca1; logic [3:0] crob;
    } vec_t;

    function automatic vec_t mk(logic [1:0] den, logic [5:0] p0, p1, logic [4:0] a0, a1,
                                logic [1:0] cen, logic [3:0] cr0, logic cb0, logic [3:0] cr1, logic cb1,
                                logic fl, logic full, logic [3:0] rob, logic [1:0] cmt,
                                logic [5:0] cp0, cp1, logic [4:0] ca0, ca1, logic [3:0] crob);
        vec_t v;
        v.den = den; v.p0 = p0; v.p1 = p1; v.a0 = a0; v.a1 = a1;
        v.cen = cen; v.cr0 = cr0; v.cb0 = cb0; v.cr1 = cr1; v.cb1 = cb1; v.fl = fl;
        v.full = full; v.rob = rob; v.cmt = cmt;
        v.cp0 = cp0; v.cp1 = cp1; v.ca0 = ca0; v.ca1 = ca1; v.crob = crob;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] den, input logic [5:0] p0, input logic [5:0] p1,
                         input logic [1:0] cen, input logic [3:0] cr0, input logic cb0,
                         input logic [3:0] cr1, input logic cb1, input logic fl);
        dispatch_en[0] = den[0]; dispatch_en[1] = den[1];
        dispatch_phys_rd[0] = p0; dispatch_phys_rd[1] = p1;
        dispatch_arch_rd[0] = p0[4:0]; dispatch_arch_rd[1] = p1[4:0];
        complete_en[0] = cen[0]; complete_en[1] = cen[1];
        complete_rob_addr[0] = cr0; complete_bank_addr[0] = cb0;
        complete_rob_addr[1] = cr1; complete_bank_addr[1] = cb1;
        flush = fl;
    endtask

    task automatic idle();
        drive(2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    endtask

    task automatic apply(input vec_t v, input int idx);
        drive(v.den, v.p0, v.p1, v.cen, v.cr0, v.cb0, v.cr1, v.cb1, v.fl);
        dispatch_arch_rd[0] = v.a0; dispatch_arch_rd[1] = v.a1;
        @(negedge clk);
        chk($sformatf("v%0d full", idx), 32'(dispatch_full), 32'(v.full));
        chk($sformatf("v%0d rob_addr0", idx), 32'(dispatch_rob_addr[0]), 32'(v.rob));
        chk($sformatf("v%0d rob_addr1", idx), 32'(dispatch_rob_addr[1]), 32'(v.rob));
        chk($sformatf("v%0d commit_en", idx), 32'({commit_en[1], commit_en[0]}), 32'(v.cmt));
        chk($sformatf("v%0d commit_rob", idx), 32'(commit_rob_addr), 32'(v.crob));
        if (v.cmt[0]) begin
            chk($sformatf("v%0d cphys0", idx), 32'(commit_phys_rd[0]), 32'(v.cp0));
            chk($sformatf("v%0d carch0", idx), 32'(commit_arch_rd[0]), 32'(v.ca0));
        end
        if (v.cmt[1]) begin
            chk($sformatf("v%0d cphys1", idx), 32'(commit_phys_rd[1]), 32'(v.cp1));
            chk($sformatf("v%0d carch1", idx), 32'(commit_arch_rd[1]), 32'(v.ca1));
        end
        @(posedge clk); #1;
    endtask

    task automatic look(input string name, input logic full, input logic [3:0] rob,
                        input logic [1:0] cmt, input logic [3:0] crob);
        chk({name, " full"}, 32'(dispatch_full), 32'(full));
        chk({name, " rob_addr"}, 32'(dispatch_rob_addr[0]), 32'(rob));
        chk({name, " commit_en"}, 32'({commit_en[1], commit_en[0]}), 32'(cmt));
        chk({name, " commit_rob"}, 32'(commit_rob_addr), 32'(crob));
    endtask

    vec_t tbl [22];

    initial begin
        idle();
        #12;
        look("reset", 0, 0, 2'b00, 0);
        chk("bank_addr0", 32'(dispatch_bank_addr[0]), 0);
        chk("bank_addr1", 32'(dispatch_bank_addr[1]), 1);
        @(posedge clk); #1;
        rst_n = 1;

        //          den  p0 p1 a0 a1 cen cr0 b0 cr1 b1 fl | full rob cmt cp0 cp1 ca0 ca1 crob
        tbl[0]  = mk(3, 10, 11, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0);
        tbl[1]  = mk(0,  0,  0, 0, 0, 3, 0, 0, 0, 1, 0, 0, 1, 0,  0,  0, 0, 0, 0);
        tbl[2]  = mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 10, 11, 1, 2, 0);
        tbl[3]  = mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0,  0, 0, 0, 1);
        tbl[4]  = mk(1, 20,  0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0,  0, 0, 0, 1);
        tbl[5]  = mk(0,  0,  0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 2, 0,  0,  0, 0, 0, 1);
        tbl[6]  = mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0,  0,  0, 0, 0, 1);
        tbl[7]  = mk(0,  0,  0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2, 0,  0,  0, 0, 0, 1);
        tbl[8]  = mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 20,  0, 3, 0, 1);
        tbl[9]  = mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0,  0,  0, 0, 0, 2);
        tbl[10] = mk(3, 30, 31, 4, 5, 0, 0, 0, 0, 0, 0, 0, 2, 0,  0,  0, 0, 0, 2);
        tbl[11] = mk(3, 32, 33, 6, 7, 0, 0, 0, 0, 0, 0, 0, 3, 0,  0,  0, 0, 0, 2);
        tbl[12] = mk(0,  0,  0, 0, 0, 3, 3, 0, 3, 1, 0, 0, 4, 0,  0,  0, 0, 0, 2);
        tbl[13] = mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0,  0,  0, 0, 0, 2);
        tbl[14] = mk(0,  0,  0, 0, 0, 3, 2, 0, 2, 1, 0, 0, 4, 0,  0,  0, 0, 0, 2);
        tbl[15] = mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 3, 30, 31, 4, 5, 2);
        tbl[16] = mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 3, 32, 33, 6, 7, 3);
        tbl[17] = mk(3, 40, 41, 8, 9, 0, 0, 0, 0, 0, 0, 0, 4, 0,  0,  0, 0, 0, 4);
        tbl[18] = mk(0,  0,  0, 0, 0, 3, 4, 0, 4, 0, 0, 0, 5, 0,  0,  0, 0, 0, 4);
        tbl[19] = mk(0,  0,  0, 0, 0, 2, 0, 0, 4, 1, 0, 0, 5, 0,  0,  0, 0, 0, 4);
        tbl[20] = mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 3, 40, 41, 8, 9, 4);
        tbl[21] = mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0,  0,  0, 0, 0, 5);
        for (int i = 0; i < 22; i++) apply(tbl[i], i);

        // async reset while a row is committing
        drive(2'b11, 50, 51, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(2'b00, 0, 0, 2'b11, 5, 0, 5, 1, 0);
        @(posedge clk); #1;
        idle();
        #1;
        look("pre_rst", 0, 6, 2'b11, 5);
        rst_n = 0;
        #1;
        look("async_rst", 0, 0, 2'b00, 0);
        @(posedge clk); #1;
        rst_n = 1;

        // fill all rows, then retire row 0 while a dispatch is blocked
        for (int k = 0; k < 16; k++) begin
            drive(2'b11, 6'(k), 6'(k + 16), 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            chk($sformatf("fill%0d full", k), 32'(dispatch_full), 0);
            chk($sformatf("fill%0d rob", k), 32'(dispatch_rob_addr[0]), k);
            @(posedge clk); #1;
        end
        drive(2'b11, 60, 61, 0, 0, 0, 0, 0, 0);
        @(negedge clk); look("fill16", 1, 0, 2'b00, 0);
        @(posedge clk); #1;
        idle();
        @(negedge clk); look("full_hold", 1, 0, 2'b00, 0);
        @(posedge clk); #1;
        drive(2'b00, 0, 0, 2'b11, 0, 0, 0, 1, 0);
        @(posedge clk); #1;
        drive(2'b11, 62, 63, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        look("full_commit", 1, 0, 2'b11, 0);
        chk("full_commit cphys0", 32'(commit_phys_rd[0]), 0);
        chk("full_commit cphys1", 32'(commit_phys_rd[1]), 16);
        @(posedge clk); #1;
        idle();
        @(negedge clk); look("after_full", 0, 0, 2'b00, 1);
        @(posedge clk); #1;
        drive(2'b11, 62, 63, 0, 0, 0, 0, 0, 0);
        @(negedge clk); look("wrap_disp", 0, 0, 2'b00, 1);
        @(posedge clk); #1;
        idle();
        @(negedge clk); look("refull", 1, 1, 2'b00, 1);

        // flush with occupied rows, a ready head and a same-cycle dispatch
        @(posedge clk); #1;
        drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
        @(posedge clk); #1;
        idle();
        @(negedge clk); look("flush1", 0, 0, 2'b00, 0);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            drive(2'b11, 6'(k + 1), 6'(k + 33), 0, 0, 0, 0, 0, 0);
            @(posedge clk); #1;
        end
        drive(2'b00, 0, 0, 2'b11, 0, 0, 0, 1, 0);
        @(posedge clk); #1;
        drive(2'b11, 9, 9, 0, 0, 0, 0, 0, 1);
        @(negedge clk); look("flush_cycle", 0, 5, 2'b00, 0);
        @(posedge clk); #1;
        idle();
        @(negedge clk); look("post_flush", 0, 0, 2'b00, 0);
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
